// File: rtl/snn_window_controller.sv
// -----------------------------------------------------------------------------
// snn_window_controller
//
// Sequences one inference of the 4-sensor / EXCNUM-output SNN core:
// latch the sensor words, pulse the core reset for one cycle, enable the core
// for WINDOW cycles, drain PIPE_LAT cycles for late spikes, then report the
// per-neuron spike counts and a steering decision with a one-cycle done pulse.
//
// Handshake: start is a request sampled only while idle (busy=0). Once it is
// accepted, busy stays high until the cycle after done, and every further start
// is dropped. done is a single-cycle strobe; spike_cnt and decision stay stable
// from done until the next accepted start clears them. abort cancels a running
// inference without a done strobe.
//
// Ports
//   clk, rst             clock, synchronous active-high reset
//   start, abort         inference request / cancel
//   sens_{fl,ml,mr,fr}_in  sensor words from the front-end
//   snn_spike            output spikes from the core, one bit per neuron
//   sens_{fl,ml,mr,fr}_q   latched sensor words driven to the core
//   snn_en, snn_rst      core enable / core membrane reset
//   busy, done           inference in progress / results valid strobe
//   spike_cnt            per-neuron counts, neuron i at [i*CNTW +: CNTW]
//   decision             00 none, 01 neuron0, 10 neuron1, 11 nonzero tie
//   state_dbg            current FSM state, for observation only
// -----------------------------------------------------------------------------
module snn_window_controller #(
    parameter int EXCNUM   = 2,
    parameter int SENSW    = 12,
    parameter int WINDOW   = 64,
    parameter int PIPE_LAT = 2,
    parameter int CNTW     = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     abort,
    input  logic [SENSW-1:0]         sens_fl_in,
    input  logic [SENSW-1:0]         sens_ml_in,
    input  logic [SENSW-1:0]         sens_mr_in,
    input  logic [SENSW-1:0]         sens_fr_in,
    input  logic [EXCNUM-1:0]        snn_spike,
    output logic [SENSW-1:0]         sens_fl_q,
    output logic [SENSW-1:0]         sens_ml_q,
    output logic [SENSW-1:0]         sens_mr_q,
    output logic [SENSW-1:0]         sens_fr_q,
    output logic                     snn_en,
    output logic                     snn_rst,
    output logic                     busy,
    output logic                     done,
    output logic [EXCNUM*CNTW-1:0]   spike_cnt,
    output logic [1:0]               decision,
    output logic [2:0]               state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_RUN    = 3'd2,
        S_DRAIN  = 3'd3,
        S_REPORT = 3'd4
    } state_t;

    // One step counter times both RUN and DRAIN; it restarts at 0 on entry.
    localparam int STEPW = $clog2(WINDOW + PIPE_LAT + 1);
    localparam logic [STEPW-1:0] RUN_LAST   = STEPW'(WINDOW - 1);
    localparam logic [STEPW-1:0] DRAIN_LAST = STEPW'((PIPE_LAT > 0) ? PIPE_LAT - 1 : 0);
    localparam logic [CNTW-1:0]  CNT_MAX    = '1;

    state_t                 state_q, state_d;
    logic [STEPW-1:0]       step_q, step_d;
    logic [EXCNUM*CNTW-1:0] cnt_nxt;
    logic [CNTW-1:0]        c0_nxt, c1_nxt;
    logic [1:0]             dec_nxt;
    logic                   counting;

    assign state_dbg = state_q;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            step_q  <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        step_d  = '0;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_CLEAR;
            end
            S_CLEAR: begin
                state_d = abort ? S_IDLE : S_RUN;
            end
            S_RUN: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (step_q == RUN_LAST) begin
                    state_d = (PIPE_LAT > 0) ? S_DRAIN : S_REPORT;
                end else begin
                    step_d = step_q + STEPW'(1);
                end
            end
            S_DRAIN: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (step_q == DRAIN_LAST) begin
                    state_d = S_REPORT;
                end else begin
                    step_d = step_q + STEPW'(1);
                end
            end
            S_REPORT: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Saturating spike counters; the cycle that carries abort is still counted.
    always_comb begin
        counting = (state_q == S_RUN) || (state_q == S_DRAIN);
        cnt_nxt  = spike_cnt;
        for (int i = 0; i < EXCNUM; i++) begin
            if (counting && snn_spike[i] && (spike_cnt[i*CNTW +: CNTW] != CNT_MAX)) begin
                cnt_nxt[i*CNTW +: CNTW] = spike_cnt[i*CNTW +: CNTW] + CNTW'(1);
            end
        end
    end

    // Decision is taken from the counts that will be visible during REPORT,
    // so a spike in the last DRAIN cycle still influences it.
    always_comb begin
        c0_nxt = cnt_nxt[0 +: CNTW];
        c1_nxt = cnt_nxt[CNTW +: CNTW];
        if ((c0_nxt == '0) && (c1_nxt == '0)) begin
            dec_nxt = 2'b00;
        end else if (c0_nxt > c1_nxt) begin
            dec_nxt = 2'b01;
        end else if (c1_nxt > c0_nxt) begin
            dec_nxt = 2'b10;
        end else begin
            dec_nxt = 2'b11;
        end
    end

    // Registered outputs decoded from the next state, so they are valid in the
    // same cycle the state is entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            snn_en    <= 1'b0;
            snn_rst   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            sens_fl_q <= '0;
            sens_ml_q <= '0;
            sens_mr_q <= '0;
            sens_fr_q <= '0;
            spike_cnt <= '0;
            decision  <= 2'b00;
        end else begin
            snn_rst <= (state_d == S_CLEAR);
            snn_en  <= (state_d == S_RUN);
            busy    <= (state_d != S_IDLE);
            done    <= (state_d == S_REPORT);
            if ((state_q == S_IDLE) && start) begin
                sens_fl_q <= sens_fl_in;
                sens_ml_q <= sens_ml_in;
                sens_mr_q <= sens_mr_in;
                sens_fr_q <= sens_fr_in;
            end
            if (state_d == S_CLEAR) begin
                spike_cnt <= '0;
                decision  <= 2'b00;
            end else begin
                spike_cnt <= cnt_nxt;
                if (state_d == S_REPORT) decision <= dec_nxt;
            end
        end
    end

endmodule

// File: tb/tb_snn_window_controller.sv
module tb_snn_window_controller;

    localparam int W    = 8;
    localparam int P    = 2;
    localparam int KREP = W + 2 + P;   // offset of the done cycle from the start edge

    logic        clk = 1'b0;
    logic        rst, start, abort;
    logic [11:0] sens_fl_in, sens_ml_in, sens_mr_in, sens_fr_in;
    logic [1:0]  snn_spike;

    logic [11:0] a_fl, a_ml, a_mr, a_fr, b_fl, b_ml, b_mr, b_fr;
    logic        a_en, a_rst, a_busy, a_done, b_en, b_rst, b_busy, b_done;
    logic [15:0] a_cnt;
    logic [5:0]  b_cnt;
    logic [1:0]  a_dec, b_dec;
    logic [2:0]  a_state, b_state;

    int checks = 0;
    int failures = 0;

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- DUTs: CNTW=8 and CNTW=3, same stimulus ----------------
    snn_window_controller #(.EXCNUM(2), .SENSW(12), .WINDOW(W), .PIPE_LAT(P), .CNTW(8)) dut_a (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .sens_fl_in(sens_fl_in), .sens_ml_in(sens_ml_in), .sens_mr_in(sens_mr_in), .sens_fr_in(sens_fr_in),
        .snn_spike(snn_spike),
        .sens_fl_q(a_fl), .sens_ml_q(a_ml), .sens_mr_q(a_mr), .sens_fr_q(a_fr),
        .snn_en(a_en), .snn_rst(a_rst), .busy(a_busy), .done(a_done),
        .spike_cnt(a_cnt), .decision(a_dec), .state_dbg(a_state)
    );

    snn_window_controller #(.EXCNUM(2), .SENSW(12), .WINDOW(W), .PIPE_LAT(P), .CNTW(3)) dut_b (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .sens_fl_in(sens_fl_in), .sens_ml_in(sens_ml_in), .sens_mr_in(sens_mr_in), .sens_fr_in(sens_fr_in),
        .snn_spike(snn_spike),
        .sens_fl_q(b_fl), .sens_ml_q(b_ml), .sens_mr_q(b_mr), .sens_fr_q(b_fr),
        .snn_en(b_en), .snn_rst(b_rst), .busy(b_busy), .done(b_done),
        .spike_cnt(b_cnt), .decision(b_dec), .state_dbg(b_state)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Timeline view: m_k counts cycles since the accepted start edge.
    // k=1 core reset, k=2..W+1 enable window, up to W+1+P drain, KREP report.
    bit          m_act;
    int          m_k;
    logic [11:0] m_sq [4];
    int          m_cnt [2][2];
    logic [1:0]  m_dec [2];
    int          cmax [2];

    function automatic logic [1:0] decide(input int c0, input int c1);
        if (c0 == 0 && c1 == 0) return 2'b00;
        if (c0 > c1) return 2'b01;
        if (c1 > c0) return 2'b10;
        return 2'b11;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_act = 1'b0;
            m_k   = 0;
            for (int j = 0; j < 4; j++) m_sq[j] = '0;
            for (int m = 0; m < 2; m++) begin
                m_cnt[m][0] = 0;
                m_cnt[m][1] = 0;
                m_dec[m]    = 2'b00;
            end
        end else if (!m_act) begin
            if (start) begin
                m_act = 1'b1;
                m_k   = 1;
                m_sq[0] = sens_fl_in; m_sq[1] = sens_ml_in;
                m_sq[2] = sens_mr_in; m_sq[3] = sens_fr_in;
                for (int m = 0; m < 2; m++) begin
                    m_cnt[m][0] = 0;
                    m_cnt[m][1] = 0;
                    m_dec[m]    = 2'b00;
                end
            end
        end else if (m_k == KREP) begin
            m_act = 1'b0;
        end else begin
            if (m_k >= 2) begin
                for (int m = 0; m < 2; m++)
                    for (int i = 0; i < 2; i++)
                        if (snn_spike[i] && m_cnt[m][i] < cmax[m]) m_cnt[m][i]++;
            end
            if (abort) begin
                m_act = 1'b0;
            end else begin
                m_k++;
                if (m_k == KREP)
                    for (int m = 0; m < 2; m++) m_dec[m] = decide(m_cnt[m][0], m_cnt[m][1]);
            end
        end

        // compare after the DUT registers have settled
        #1;
        chk("a_busy", 32'(a_busy), 32'(m_act));
        chk("a_snn_rst", 32'(a_rst), 32'(m_act && m_k == 1));
        chk("a_snn_en", 32'(a_en), 32'(m_act && m_k >= 2 && m_k <= W + 1));
        chk("a_done", 32'(a_done), 32'(m_act && m_k == KREP));
        chk("a_sens", {a_fl, a_ml, a_mr, a_fr}, {m_sq[0], m_sq[1], m_sq[2], m_sq[3]});
        chk("a_spike_cnt", 32'(a_cnt), 32'(m_cnt[0][1] * 256 + m_cnt[0][0]));
        chk("a_decision", 32'(a_dec), 32'(m_dec[0]));
        chk("b_busy", 32'(b_busy), 32'(m_act));
        chk("b_en_rst_done", {b_en, b_rst, b_done},
            {m_act && m_k >= 2 && m_k <= W + 1, m_act && m_k == 1, m_act && m_k == KREP});
        chk("b_sens", {b_fl, b_ml, b_mr, b_fr}, {m_sq[0], m_sq[1], m_sq[2], m_sq[3]});
        chk("b_spike_cnt", 32'(b_cnt), 32'(m_cnt[1][1] * 8 + m_cnt[1][0]));
        chk("b_decision", 32'(b_dec), 32'(m_dec[1]));
    end

    // ---------------- driver tasks ----------------
    logic [1:0] sp_pat [0:15];
    bit         st_pat [0:15];
    int         ab_at, rs_at;
    int         en_n, rs_n, done_n, done_k;
    bit         busy_at [0:15];
    logic [31:0] pr_snap;

    task automatic clear_pat();
        for (int k = 0; k < 16; k++) begin
            sp_pat[k] = 2'b00;
            st_pat[k] = 1'b0;
        end
        ab_at = 0;
        rs_at = 0;
    endtask

    task automatic rand_sens();
        sens_fl_in = 12'($urandom_range(0, 4095));
        sens_ml_in = 12'($urandom_range(0, 4095));
        sens_mr_in = 12'($urandom_range(0, 4095));
        sens_fr_in = 12'($urandom_range(0, 4095));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; start = 1'b0; abort = 1'b0; snn_spike = 2'b00;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Start an inference, then apply the pattern arrays per cycle offset k.
    task automatic run_inf(input logic [11:0] fl, input logic [11:0] ml,
                           input logic [11:0] mr, input logic [11:0] fr);
        @(negedge clk);
        start = 1'b1; abort = 1'b0; snn_spike = 2'b00;
        sens_fl_in = fl; sens_ml_in = ml; sens_mr_in = mr; sens_fr_in = fr;
        en_n = 0; rs_n = 0; done_n = 0; done_k = 0; pr_snap = '1;
        for (int k = 1; k <= 13; k++) begin
            @(negedge clk);
            busy_at[k] = a_busy;
            en_n   += int'(a_en);
            rs_n   += int'(a_rst);
            if (a_done) begin
                done_n++;
                done_k = k;
            end
            if (rs_at != 0 && k == rs_at + 1)
                pr_snap = {a_busy, a_en, a_rst, a_done, a_cnt, a_fl[11:0]};
            start     = st_pat[k];
            snn_spike = sp_pat[k];
            abort     = (k == ab_at);
            rst       = (k == rs_at);
            rand_sens();
        end
        start = 1'b0; abort = 1'b0; snn_spike = 2'b00; rst = 1'b0;
        @(negedge clk);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        cmax[0] = 255;
        cmax[1] = 7;
        rst = 1'b1; start = 1'b0; abort = 1'b0; snn_spike = 2'b00;
        sens_fl_in = '0; sens_ml_in = '0; sens_mr_in = '0; sens_fr_in = '0;
        do_reset();
        chk("reset_outputs", {a_busy, a_en, a_rst, a_done, a_dec, a_cnt}, '0);

        // 1: basic sequencing and sensor latch
        clear_pat();
        run_inf(12'd150, 12'd750, 12'd750, 12'd150);
        chk("t1_busy_T1", 32'(busy_at[1]), 32'd1);
        chk("t1_rst_cycles", 32'(rs_n), 32'd1);
        chk("t1_en_cycles", 32'(en_n), 32'd8);
        chk("t1_done_offset", 32'(done_k), 32'd12);
        chk("t1_done_count", 32'(done_n), 32'd1);
        chk("t1_sens_q", {a_fl, a_ml, a_mr, a_fr}, {12'd150, 12'd750, 12'd750, 12'd150});

        // 2: neuron0 x5 in RUN, neuron1 x2 in RUN + 1 in DRAIN
        clear_pat();
        for (int k = 2; k <= 6; k++) sp_pat[k][0] = 1'b1;
        sp_pat[2][1] = 1'b1; sp_pat[3][1] = 1'b1; sp_pat[10][1] = 1'b1;
        run_inf(12'd1, 12'd2, 12'd3, 12'd4);
        chk("t2_spike_cnt", 32'(a_cnt), 32'h0305);
        chk("t2_decision", 32'(a_dec), 32'd1);

        // 3a: no spikes
        clear_pat();
        run_inf(12'd5, 12'd6, 12'd7, 12'd8);
        chk("t3_none_cnt", 32'(a_cnt), 32'h0000);
        chk("t3_none_dec", 32'(a_dec), 32'd0);

        // 3b: 4/4 tie, last neuron1 spike in the final DRAIN cycle
        clear_pat();
        for (int k = 2; k <= 5; k++) sp_pat[k][0] = 1'b1;
        sp_pat[2][1] = 1'b1; sp_pat[3][1] = 1'b1; sp_pat[4][1] = 1'b1; sp_pat[11][1] = 1'b1;
        run_inf(12'd9, 12'd10, 12'd11, 12'd12);
        chk("t3_tie_cnt", 32'(a_cnt), 32'h0404);
        chk("t3_tie_dec", 32'(a_dec), 32'd3);

        // 4: neuron1 high across RUN+DRAIN -> 10 on CNTW=8, saturates at 7 on CNTW=3
        clear_pat();
        for (int k = 2; k <= 11; k++) sp_pat[k][1] = 1'b1;
        run_inf(12'd13, 12'd14, 12'd15, 12'd16);
        chk("t4_a_cnt", 32'(a_cnt), 32'h0A00);
        chk("t4_b_cnt_sat", 32'(b_cnt), 32'h38);
        chk("t4_b_dec", 32'(b_dec), 32'd2);

        // 5: abort on 3rd RUN cycle, partial counts kept, then a clean run
        clear_pat();
        for (int k = 2; k <= 11; k++) sp_pat[k][0] = 1'b1;
        ab_at = 4;
        run_inf(12'd17, 12'd18, 12'd19, 12'd20);
        chk("t5_no_done", 32'(done_n), 32'd0);
        chk("t5_idle_after", 32'(busy_at[5]), 32'd0);
        chk("t5_en_cycles", 32'(en_n), 32'd3);
        chk("t5_partial_cnt", 32'(a_cnt), 32'h0003);
        chk("t5_dec_none", 32'(a_dec), 32'd0);
        clear_pat();
        run_inf(12'd21, 12'd22, 12'd23, 12'd24);
        chk("t5_restart_cnt", 32'(a_cnt), 32'h0000);
        chk("t5_restart_done", 32'(done_n), 32'd1);

        // 6: start during RUN and REPORT ignored; then rst mid-RUN
        clear_pat();
        st_pat[5] = 1'b1; st_pat[12] = 1'b1;
        run_inf(12'd25, 12'd26, 12'd27, 12'd28);
        chk("t6_done_offset", 32'(done_k), 32'd12);
        chk("t6_en_cycles", 32'(en_n), 32'd8);
        chk("t6_idle_after_report", 32'(busy_at[13]), 32'd0);
        clear_pat();
        for (int k = 2; k <= 4; k++) sp_pat[k] = 2'b11;
        rs_at = 5;
        run_inf(12'd29, 12'd30, 12'd31, 12'd32);
        chk("t6_rst_outputs", pr_snap, 32'd0);
        chk("t6_rst_no_done", 32'(done_n), 32'd0);

        // random phase
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            rst       = ($urandom_range(0, 249) == 0);
            start     = ($urandom_range(0, 7) == 0);
            abort     = ($urandom_range(0, 39) == 0);
            snn_spike = 2'($urandom_range(0, 3));
            rand_sens();
        end
        @(negedge clk);
        rst = 1'b0; start = 1'b0; abort = 1'b0; snn_spike = 2'b00;
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
